// File: rtl/icecream_vend.sv
// Ice-cream vending controller: accumulates coin credit, validates a flavour
// selection against price and stock, runs a timed dispense, then hands back change.
module icecream_vend #(
  parameter  int N_FLAV     = 4,
  parameter  int CRED_W     = 8,
  parameter  int PRICE      = 25,
  parameter  int STOCK_W    = 4,
  parameter  int STOCK_INIT = 8,
  parameter  int DISP_CYC   = 4,
  localparam int SEL_W      = (N_FLAV > 1) ? $clog2(N_FLAV) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coin_valid,
  input  logic [CRED_W-1:0] coin_val,
  input  logic              sel_valid,
  input  logic [SEL_W-1:0]  sel,
  input  logic              cancel,
  input  logic              restock,
  input  logic              change_ack,
  output logic              dispense,
  output logic [SEL_W-1:0]  disp_flav,
  output logic              change_valid,
  output logic [CRED_W-1:0] change_val,
  output logic              err,
  output logic              busy,
  output logic [CRED_W-1:0] credit,
  output logic [N_FLAV-1:0] sold_out
);

  localparam int                CNT_W      = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DISP_CYC - 1);
  localparam logic [CRED_W-1:0] PRICE_C    = CRED_W'(PRICE);
  localparam logic [STOCK_W-1:0] STOCK_RLD = STOCK_W'(STOCK_INIT);

  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

  state_t             state, state_nxt;
  logic [CRED_W-1:0]  credit_nxt, change_val_nxt;
  logic [STOCK_W-1:0] stock     [N_FLAV];
  logic [STOCK_W-1:0] stock_nxt [N_FLAV];
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               dispense_nxt, change_valid_nxt, err_nxt;
  logic [SEL_W-1:0]   disp_flav_nxt;
  logic [CRED_W-1:0]  coin_add, credit_acc, credit_after;
  logic               sel_ok;

  // Credit never wraps: an overflowing coin pins the credit at full scale.
  function automatic logic [CRED_W-1:0] sat_add(input logic [CRED_W-1:0] a,
                                                input logic [CRED_W-1:0] b);
    logic [CRED_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CRED_W] ? '1 : sum[CRED_W-1:0];
  endfunction

  assign coin_add     = coin_valid ? coin_val : '0;
  assign credit_acc   = sat_add(credit, coin_add);
  assign credit_after = credit - PRICE_C;
  // Price check uses the credit held before this cycle's coin lands.
  assign sel_ok       = ({1'b0, sel} < (SEL_W + 1)'(N_FLAV)) &&
                        (stock[sel] != '0) && (credit >= PRICE_C);

  assign busy = (state == DISPENSE) || (state == CHANGE);

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < N_FLAV; i++) sold_out[i] = (stock[i] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    credit_nxt       = credit;
    stock_nxt        = stock;
    cnt_nxt          = cnt;
    dispense_nxt     = dispense;
    disp_flav_nxt    = disp_flav;
    change_valid_nxt = change_valid;
    change_val_nxt   = change_val;
    err_nxt          = 1'b0;

    case (state)
      IDLE: begin
        if (coin_valid) begin
          credit_nxt = coin_val;
          state_nxt  = CREDIT;
        end
        if (restock) begin
          for (int i = 0; i < N_FLAV; i++) stock_nxt[i] = STOCK_RLD;
        end
        if (sel_valid) err_nxt = 1'b1;
      end

      CREDIT: begin
        credit_nxt = credit_acc;
        if (cancel) begin
          // A zero credit refund has nothing to hand over, so skip the hopper.
          if (credit_acc != '0) begin
            state_nxt        = CHANGE;
            change_valid_nxt = 1'b1;
            change_val_nxt   = credit_acc;
          end else begin
            state_nxt = IDLE;
          end
        end else if (sel_valid) begin
          if (sel_ok) begin
            state_nxt     = DISPENSE;
            disp_flav_nxt = sel;
            dispense_nxt  = 1'b1;
            cnt_nxt       = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      DISPENSE: begin
        if (cnt == CNT_LAST) begin
          stock_nxt[disp_flav] = stock[disp_flav] - STOCK_W'(1);
          credit_nxt           = credit_after;
          dispense_nxt         = 1'b0;
          if (credit_after != '0) begin
            state_nxt        = CHANGE;
            change_valid_nxt = 1'b1;
            change_val_nxt   = credit_after;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      CHANGE: begin
        if (change_ack) begin
          credit_nxt       = '0;
          change_valid_nxt = 1'b0;
          change_val_nxt   = '0;
          state_nxt        = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Reset mid-transaction discards credit and reloads every flavour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit       <= '0;
      cnt          <= '0;
      dispense     <= 1'b0;
      disp_flav    <= '0;
      change_valid <= 1'b0;
      change_val   <= '0;
      err          <= 1'b0;
      for (int i = 0; i < N_FLAV; i++) stock[i] <= STOCK_RLD;
    end else begin
      credit       <= credit_nxt;
      cnt          <= cnt_nxt;
      dispense     <= dispense_nxt;
      disp_flav    <= disp_flav_nxt;
      change_valid <= change_valid_nxt;
      change_val   <= change_val_nxt;
      err          <= err_nxt;
      for (int i = 0; i < N_FLAV; i++) stock[i] <= stock_nxt[i];
    end
  end

endmodule

// File: doc/icecream_vend.md
# icecream_vend

Parametrised ice-cream vending controller: the sequential successor to the single-recipe combinational selector. It accumulates coin credit, validates a flavour selection against price and per-flavour stock, and drives a timed dispense. It then returns change through a valid/ack handshake. It sits between the coin/keypad front-end and the dispenser actuator and change hopper.

## Interface
- N_FLAV, 4, number of flavours (≥2); SEL_W = $clog2(N_FLAV)
- CRED_W, 8, credit, coin and change width
- PRICE, 25, price of one scoop (< 2^CRED_W)
- STOCK_W, 4, per-flavour stock counter width
- STOCK_INIT, 8, stock loaded at reset/restock (≤ 2^STOCK_W-1)
- DISP_CYC, 4, dispense-active cycles (≥1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- coin_valid  in  1  coin present this cycle
- coin_val  in  CRED_W  coin value
- sel_valid  in  1  flavour selection strobe
- sel  in  SEL_W  flavour index
- cancel  in  1  refund request
- restock  in  1  reload all stocks (honoured only in IDLE)
- change_ack  in  1  hopper accepted change
- dispense  out  1  actuator enable
- disp_flav  out  SEL_W  flavour being dispensed
- change_valid  out  1  change offered
- change_val  out  CRED_W  change amount
- err  out  1  one-cycle pulse: rejected selection
- busy  out  1  high in DISPENSE or CHANGE
- credit  out  CRED_W  current credit
- sold_out  out  N_FLAV  bit i = (stock[i]==0)

## Operation
- Reset values: state IDLE, credit 0, every stock = STOCK_INIT, dispense/change_valid/err/busy 0, disp_flav 0, change_val 0.
- States: IDLE, CREDIT, DISPENSE, CHANGE.
- IDLE: coin_valid → credit=coin_val, go CREDIT. restock → all stocks = STOCK_INIT. sel_valid → err pulse. cancel ignored.
- CREDIT, per-cycle priority is cancel > sel > coin:
  - cancel → go CHANGE with change_val = credit + coin_val (coin included if coin_valid).
  - sel_valid with stock[sel]==0, or sel ≥ N_FLAV, or pre-coin credit < PRICE → err pulse, stay.
  - sel_valid accepted → go DISPENSE; disp_flav=sel latched.
  - coin_valid is always accumulated unless cancel, including the cycle a selection is accepted.
- Credit addition saturates at 2^CRED_W-1; excess is lost, with no wrap.
- DISPENSE: dispense=1 for exactly DISP_CYC cycles. Internal counter runs 0..DISP_CYC-1. Coins, sel, cancel and restock are ignored.
  - On the final-cycle edge: stock[disp_flav] -= 1, credit -= PRICE.
  - If the resulting credit > 0 go CHANGE, else go IDLE.
- CHANGE: change_valid=1 and change_val=credit, held stable until change_ack. On the ack edge: credit=0, change_valid=0, go IDLE. Inputs other than change_ack are ignored.
- Stock never underflows, because a selection is only accepted when stock > 0.
- Async reset mid-DISPENSE or mid-CHANGE drops all outputs immediately. Credit is lost and stock reloads.

## Timing
- All outputs are registered except sold_out and busy, which are decoded from registers.
- Coin at edge t → credit visible at t+1.
- Selection accepted at edge t → dispense high in cycles t+1..t+DISP_CYC. Stock and credit update at the end of cycle t+DISP_CYC. change_valid or IDLE follows at t+DISP_CYC+1.
- err is high for the single cycle after the offending sel_valid edge.
- change_ack sampled in the same cycle change_valid rises is honoured: 1-cycle minimum handshake.
- cancel → change_valid in the next cycle. If credit is 0 (only possible with a zero-valued coin), go IDLE directly.

## Test plan
- Reset, then coins 10,10,10, then sel=2 → dispense high 4 cycles with disp_flav=2. Then change_valid with change_val=5, stock[2] 8→7. change_ack → IDLE, credit 0.
- Credit 20, sel=1 → err pulse, state CREDIT, credit 20. Add coin 5, sel=1 → dispense, then IDLE directly with no change.
- Drain flavour 0 with 8 exact-price purchases → sold_out[0]=1. A 9th sel=0 with credit 25 → err. restock in IDLE → sold_out[0]=0, stock 8.
- Credit 15, cancel and coin 10 in the same cycle → change_val=25 next cycle. Hold ack low 5 cycles → value stable. Ack → IDLE.
- Coins 200, 100 (CRED_W=8) → credit saturates at 255. sel=3 → change_val=230.
- Assert rst during the 2nd dispense cycle → dispense=0 immediately, credit 0, all stocks 8, state IDLE after release.
